riscv_mem_req_adapter: RTL and testbench
========================================

Name: riscv_mem_req_adapter

Overview:
- Request-side front end for one tightly coupled memory port (IROM, IRAM or DRAM) of the RISC-V memory subsystem.
- Converts a valid/ready request channel and a valid/ready response channel into the memory's fixed-timing interface: enable per access, read data one cycle later, no stall.
- Provides response buffering, outstanding-access credit control and alignment checking.
- Misaligned accesses are answered with an error response and never reach the memory.

Parameters:
DATA_WIDTH, 33, data bus width including the capability tag bit (33 or 65).
ADDR_WIDTH, 32, byte address width.
RSP_FIFO_DEPTH, 3, response FIFO entries; also the credit limit on accepted-but-unconsumed accesses (min 2).

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid&ready
req_addr_i  input  ADDR_WIDTH  byte address
req_we_i  input  1  1=write, 0=read
req_be_i  input  4  byte enables for non-cap writes
req_is_cap_i  input  1  capability-width access
req_wdata_i  input  DATA_WIDTH  write data
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid&ready
rsp_rdata_o  output  DATA_WIDTH  read data; 0 for writes and errors
rsp_err_o  output  1  misalignment or memory error
mem_en_o  output  1  memory enable
mem_addr_o  output  ADDR_WIDTH  memory byte address
mem_is_cap_o  output  1  capability access flag
mem_we_o  output  1  write enable
mem_be_o  output  4  byte enables
mem_wdata_o  output  DATA_WIDTH  write data
mem_rdata_i  input  DATA_WIDTH  read data, valid the cycle after mem_en_o
mem_ready_i  input  1  memory can accept this cycle
mem_error_i  input  1  error, sampled with mem_rdata_i

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FIFO emptied; in-flight slot cleared.
  - All outputs 0 the following cycle: req_ready_o=0 while rst_i asserted, rsp_valid_o=0, mem_en_o=0.
  - An access in flight at reset is discarded; no response is produced for it.
- Credit:
  - occ = fifo_count + inflight, where inflight is 0 or 1.
  - req_ready_o = ~rst_i & mem_ready_i & (occ < RSP_FIFO_DEPTH).
  - Pops in the current cycle are not credited; with the default depth, sustained throughput is 1 access per cycle.
- Alignment:
  - misalign = req_is_cap_i ? (addr[2:0] != 0 when DATA_WIDTH=65, addr[1:0] != 0 when 33) : (addr[1:0] != 0).
  - Byte/halfword sub-word accesses are expressed through req_be_i and are never misaligned.
- Issue (cycle T, accept = req_valid_i & req_ready_o):
  - mem_en_o = accept & ~misalign, combinational and zero latency.
  - mem_addr_o, mem_we_o, mem_is_cap_o and mem_wdata_o pass through from the request.
  - mem_be_o = req_is_cap_i ? 4'hF : req_be_i.
  - mem_en_o is never asserted while mem_ready_i=0.
- In-flight register: on accept, set inflight=1 and record we, misalign. Otherwise inflight=0 next cycle.
- Capture (cycle T+1, inflight=1): push one FIFO entry.
  - rdata = (we | misalign) ? 0 : mem_rdata_i.
  - err = misalign | (~misalign & mem_error_i).
  - The push is unconditional: credit guarantees space.
- Response:
  - rsp_valid_o = FIFO not empty; head is presented in cycle T+2 at the earliest.
  - Latency from accept to rsp_valid_o is 2 cycles with an empty FIFO.
  - Head is stable while rsp_valid_o & ~rsp_ready_i.
- FIFO:
  - Circular, power-of-two-agnostic pointers that wrap at RSP_FIFO_DEPTH-1 to 0.
  - fifo_count in [0, RSP_FIFO_DEPTH].
  - Simultaneous push and pop leaves count unchanged.
  - Pop on an empty FIFO and push on a full FIFO cannot occur; verify with assertions.
- Ordering: responses are returned strictly in request order. No reordering and no write/read bypass.

Test Plan:
- Read, DATA_WIDTH=33: addr 0x100, mem returns 0x0_DEADBEEF at T+1 -> mem_en_o pulses at T; rsp_valid_o at T+2 with rdata 0x0_DEADBEEF, err=0.
- Back-to-back reads: 8 consecutive reads, rsp_ready_i=1 -> req_ready_o stays 1; 8 responses in order, one per cycle from T+2.
- Backpressure: rsp_ready_i=0, issue 5 reads -> exactly 3 accepted, req_ready_o=0 after the third. Then release -> 3 responses in order, and the remaining 2 are accepted.
- Misaligned: cap read at 0x104 with DATA_WIDTH=65 -> mem_en_o stays 0; response err=1, rdata=0. Word read at 0x102 gives the same result.
- Write: be=4'b0011, is_cap=0 -> mem_be_o=0011 and mem_we_o=1. Cap write -> mem_be_o=1111. Each write returns a response with rdata=0, err=0; mem_error_i=1 at T+1 gives err=1.
- Reset mid-flight: accept a read, assert rst_i at T+1 -> no response ever appears; all outputs 0. After rst_i deasserts, a new read completes normally.

Source files
------------

// File: rtl/riscv_mem_req_adapter.sv
// Request-side adapter for one tightly coupled memory port: valid/ready request and
// response channels over a fixed one-cycle-latency memory, with credit and alignment checks.
module riscv_mem_req_adapter #(
    parameter int DATA_WIDTH     = 33,
    parameter int ADDR_WIDTH     = 32,
    parameter int RSP_FIFO_DEPTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_we_i,
    input  logic [3:0]            req_be_i,
    input  logic                  req_is_cap_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_is_cap_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i,
    input  logic                  mem_error_i
);

    localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(RSP_FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(RSP_FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C   = CW'(RSP_FIFO_DEPTH);

    // Each entry is {err, rdata}.
    logic [DATA_WIDTH:0]   fifo_mem [RSP_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic                  inflight;
    logic                  inflight_we;
    logic                  inflight_mis;

    logic                  misalign;
    logic [CW:0]           occ;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH:0]   push_entry;
    logic [DATA_WIDTH:0]   head;

    always_comb begin
        misalign = (req_addr_i[1:0] != 2'b00);
        if (req_is_cap_i && DATA_WIDTH == 65)
            misalign = (req_addr_i[2:0] != 3'b000);
    end

    // Occupancy counts the access still in flight, so a full FIFO can never be overrun.
    assign occ         = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign req_ready_o = ~rst_i & mem_ready_i & (occ < DEPTH_C);
    assign accept      = req_valid_i & req_ready_o;

    assign mem_en_o     = accept & ~misalign;
    assign mem_addr_o   = req_addr_i;
    assign mem_we_o     = req_we_i;
    assign mem_is_cap_o = req_is_cap_i;
    assign mem_wdata_o  = req_wdata_i;
    assign mem_be_o     = req_is_cap_i ? 4'hF : req_be_i;

    assign push       = inflight;
    assign pop        = rsp_valid_o & rsp_ready_i;
    assign push_entry = {inflight_mis | (~inflight_mis & mem_error_i),
                         (inflight_we | inflight_mis) ? {DATA_WIDTH{1'b0}} : mem_rdata_i};

    assign head        = fifo_mem[rd_ptr];
    assign rsp_valid_o = (fifo_count != '0);
    assign rsp_rdata_o = rsp_valid_o ? head[DATA_WIDTH-1:0] : '0;
    assign rsp_err_o   = rsp_valid_o & head[DATA_WIDTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            inflight     <= 1'b0;
            inflight_we  <= 1'b0;
            inflight_mis <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_we  <= req_we_i;
                inflight_mis <= misalign;
            end
            if (push)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage is left unreset; entries are only read once fifo_count marks them valid.
    always_ff @(posedge clk_i) begin
        if (push)
            fifo_mem[wr_ptr] <= push_entry;
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_count == FULL_C));
    assert property (@(posedge clk_i) disable iff (rst_i) !(pop && fifo_count == '0));
    assert property (@(posedge clk_i) !(mem_en_o && !mem_ready_i));

endmodule

// File: tb/tb_riscv_mem_req_adapter.sv
// Scoreboard bench for riscv_mem_req_adapter (DATA_WIDTH=65): directed requests push
// expected responses; an independent monitor pops and compares on each response handshake.
module tb_riscv_mem_req_adapter;

    localparam int DW = 65;
    localparam logic [DW-1:0] JUNK = 65'h1_5A5A_A5A5_1234_9876;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            acc;
        logic          chk_lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [31:0]   req_addr_i;
    logic          req_we_i;
    logic [3:0]    req_be_i;
    logic          req_is_cap_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          mem_en_o;
    logic [31:0]   mem_addr_o;
    logic          mem_is_cap_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_ready_i;
    logic          mem_error_i = 1'b0;

    logic          merr_flag = 1'b0;
    int            cyc = 0;
    int            checks = 0;
    int            passes = 0;
    int            total_wait = 0;
    exp_t          exp_q [$];

    riscv_mem_req_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .RSP_FIFO_DEPTH(3)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_be_i(req_be_i), .req_is_cap_i(req_is_cap_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_is_cap_o(mem_is_cap_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .mem_error_i(mem_error_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] data_of(input logic [31:0] a);
        if (a == 32'h100) return 65'h0_0000_0000_DEAD_BEEF;
        return {1'b1, ~a, a};
    endfunction

    // Memory model: one-cycle read latency, junk on the bus otherwise.
    always @(posedge clk) begin
        mem_rdata_i <= (mem_en_o && !mem_we_o) ? data_of(mem_addr_o) : JUNK;
        mem_error_i <= mem_en_o & merr_flag;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic we, input logic cap,
                            input logic merr, input logic chk_lat);
        exp_t e;
        logic mis;
        mis       = cap ? (addr[2:0] != 3'b0) : (addr[1:0] != 2'b0);
        e.rdata   = (we || mis) ? '0 : data_of(addr);
        e.err     = mis | merr;
        e.acc     = cyc;
        e.chk_lat = chk_lat;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic cap, input logic [DW-1:0] wdata, input logic merr,
                        input logic exp_rsp, input logic chk_lat);
        int   waited;
        logic mis;
        waited = 0;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_addr_i   = addr;
        req_we_i     = we;
        req_be_i     = be;
        req_is_cap_i = cap;
        req_wdata_i  = wdata;
        merr_flag    = merr;
        #1;
        while (!req_ready_o && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        total_wait += waited;
        if (!req_ready_o) begin
            check("accept_timeout", 65'(req_ready_o), 65'd1);
        end else begin
            mis = cap ? (addr[2:0] != 3'b0) : (addr[1:0] != 2'b0);
            check("mem_en", 65'(mem_en_o), 65'(!mis));
            if (!mis) begin
                check("mem_be", 65'(mem_be_o), 65'(cap ? 4'hF : be));
                check("mem_we", 65'(mem_we_o), 65'(we));
                check("mem_addr", 65'(mem_addr_o), 65'(addr));
                if (we) check("mem_wdata", mem_wdata_o, wdata);
            end
            if (exp_rsp) push_exp(addr, we, cap, merr, chk_lat);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic cap, input logic chk_lat);
        send(addr, 1'b0, 4'hF, cap, '0, 1'b0, 1'b1, chk_lat);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid_i = 1'b0;
        merr_flag   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 65'(exp_q.size()), 65'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response",
                             rsp_rdata_o, rsp_err_o);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata_o, e.rdata);
                    check("rsp_err", 65'(rsp_err_o), 65'(e.err));
                    if (e.chk_lat) check("rsp_latency", 65'(cyc - e.acc), 65'd2);
                end
            end
        end
    end

    logic [31:0] bp_addr [5];
    int          idx;

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b1; req_addr_i = '0; req_we_i = 1'b0; req_be_i = 4'hF;
        req_is_cap_i = 1'b0; req_wdata_i = '0; rsp_ready_i = 1'b1; mem_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 65'(req_ready_o), 65'd0);
        check("rst_rsp_valid", 65'(rsp_valid_o), 65'd0);
        check("rst_mem_en", 65'(mem_en_o), 65'd0);
        @(negedge clk);
        rst_i = 1'b0;
        req_valid_i = 1'b0;

        // Single read, two-cycle latency.
        rd(32'h100, 1'b0, 1'b1);
        idle();
        drain();

        // Eight back-to-back reads, no stall expected.
        total_wait = 0;
        for (int i = 0; i < 8; i++) rd(32'h200 + 32'(4 * i), 1'b0, 1'b1);
        idle();
        check("b2b_no_stall", 65'(total_wait), 65'd0);
        drain();

        // Backpressure: credit limit of three.
        bp_addr = '{32'h500, 32'h504, 32'h508, 32'h50C, 32'h510};
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rsp_ready_i = 1'b0;
            if (idx < 5) begin
                req_valid_i = 1'b1; req_addr_i = bp_addr[idx]; req_we_i = 1'b0;
                req_is_cap_i = 1'b0; req_be_i = 4'hF;
                #1;
                if (req_ready_o) begin
                    push_exp(bp_addr[idx], 1'b0, 1'b0, 1'b0, 1'b0);
                    idx++;
                end
            end else begin
                req_valid_i = 1'b0;
            end
        end
        check("bp_accepted", 65'(idx), 65'd3);
        check("bp_ready_low", 65'(req_ready_o), 65'd0);
        @(negedge clk);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        for (int j = idx; j < 5; j++) rd(bp_addr[j], 1'b0, 1'b0);
        idle();
        drain();

        // Alignment: cap at 0x104 and word at 0x102 are misaligned; cap at 0x108 is not.
        rd(32'h104, 1'b1, 1'b1);
        rd(32'h102, 1'b0, 1'b1);
        rd(32'h108, 1'b1, 1'b1);
        idle();
        drain();

        // Writes, including one answered with a memory error.
        send(32'h300, 1'b1, 4'b0011, 1'b0, 65'h0_0000_0000_0000_ABCD, 1'b0, 1'b1, 1'b1);
        send(32'h308, 1'b1, 4'b0001, 1'b1, 65'h1_CAFE_F00D_1234_5678, 1'b0, 1'b1, 1'b1);
        send(32'h310, 1'b1, 4'b1100, 1'b0, 65'h0_0000_0000_1111_2222, 1'b1, 1'b1, 1'b1);
        idle();
        drain();

        // Memory not ready: nothing is accepted or issued.
        @(negedge clk);
        mem_ready_i = 1'b0; req_valid_i = 1'b1; req_addr_i = 32'h600; req_we_i = 1'b0;
        #1;
        check("mem_busy_ready", 65'(req_ready_o), 65'd0);
        check("mem_busy_en", 65'(mem_en_o), 65'd0);
        @(negedge clk);
        mem_ready_i = 1'b1;
        req_valid_i = 1'b0;

        // Reset while a read is in flight: its response is dropped.
        send(32'h400, 1'b0, 4'hF, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("midrst_req_ready", 65'(req_ready_o), 65'd0);
        check("midrst_mem_en", 65'(mem_en_o), 65'd0);
        @(negedge clk);
        #1;
        check("postrst_rsp_valid", 65'(rsp_valid_o), 65'd0);
        check("postrst_rsp_rdata", rsp_rdata_o, '0);
        check("postrst_req_ready", 65'(req_ready_o), 65'd0);
        @(negedge clk);
        rst_i = 1'b0;
        req_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        rd(32'h404, 1'b0, 1'b1);
        idle();
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
